// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer engine.
package fc_pkg;

  typedef enum logic [1:0] {
    LOAD_X  = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } fc_state_e;

  // Working width for the clamp/ReLU helpers; accumulators must fit in it.
  localparam int SAT_W = 64;

  // Accumulator width that cannot overflow: full product plus growth over N terms.
  function automatic int acc_width(input int t, input int n);
    return 2 * t + $clog2(n);
  endfunction

  // Clamp a signed value into the signed t-bit range.
  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                     input int t);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Rectifier: negative values become zero.
  function automatic logic signed [SAT_W-1:0] relu(input logic signed [SAT_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: signed multiply, wide accumulate, then clamp and optional ReLU.
module fc_mac_lane import fc_pkg::*; #(
  parameter int T = 16,
  parameter int N = 8,
  parameter int R = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic signed [T-1:0] w,
  input  logic signed [T-1:0] x,
  output logic signed [T-1:0] result
);

  localparam int AW = acc_width(T, N);

  logic signed [2*T-1:0]   prod;
  logic signed [AW-1:0]    acc;
  logic signed [SAT_W-1:0] acc_wide;
  logic signed [SAT_W-1:0] clamped;

  assign prod = (2 * T)'(w) * (2 * T)'(x);

  // Accumulator: clear has priority over accumulate.
  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + AW'(prod);
  end

  // Result path: clamp to T bits, then rectify when ReLU is selected.
  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    acc_wide = SAT_W'(acc);
    clamped  = sat_to(acc_wide, T);
    if (R != 0) clamped = relu(clamped);
    result = clamped[T-1:0];
  end

endmodule

// File: rtl/fc_mvm_par.sv
// Fully-connected layer engine: y = f(W*x) with P parallel lanes and writable banked weights.
module fc_mvm_par import fc_pkg::*; #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 16,
  parameter int P = 2,
  parameter int R = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic [T-1:0]             input_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [T-1:0]             output_data,
  input  logic                     w_wr_en,
  input  logic [$clog2(M*N)-1:0]   w_addr,
  input  logic [T-1:0]             w_data,
  output logic                     w_ready
);

  localparam int G     = M / P;
  localparam int DEPTH = G * N;
  localparam int BAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam int XW    = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;

  fc_state_e         state;
  logic [XW-1:0]     x_cnt;
  logic [CW-1:0]     col_cnt;
  logic [GW-1:0]     grp;
  logic [PW-1:0]     drain_idx;

  logic signed [T-1:0] x_buf [N];
  logic signed [T-1:0] x_q;
  logic signed [T-1:0] w_mem [P][DEPTH];
  logic signed [T-1:0] w_q [P];
  logic signed [T-1:0] lane_res [P];
  logic signed [T-1:0] out_rf [P];

  logic              accept;
  logic              out_fire;
  logic              lane_clr;
  logic              lane_en;
  logic [XW-1:0]     rd_col;
  logic [BAW-1:0]    rd_addr;
  logic              wr_hit;
  logic [PW-1:0]     wr_bank;
  logic [BAW-1:0]    wr_idx;

  assign accept   = input_valid & input_ready;
  assign out_fire = output_valid & output_ready;
  assign lane_clr = (state != COMPUTE);
  assign lane_en  = (state == COMPUTE) && (col_cnt < CW'(N));

  // Read pointer: the address issued on this edge feeds the MAC on the next edge,
  // so column 0 of the upcoming group is fetched while leaving LOAD_X or DRAIN.
  always_comb begin
    int col_i;
    int grp_i;
    col_i = 0;
    grp_i = int'(grp);
    if (state == COMPUTE && int'(col_cnt) + 1 < N) col_i = int'(col_cnt) + 1;
    if (state == DRAIN) grp_i = (int'(grp) + 1) % G;
    rd_col  = XW'(col_i);
    rd_addr = BAW'(grp_i * N + col_i);
  end

  // Weight write decode: row-major index to (bank = row % P, entry = (row / P) * N + col).
  always_comb begin
    int a;
    int row;
    int col;
    a       = int'(w_addr);
    row     = a / N;
    col     = a % N;
    wr_hit  = w_wr_en && w_ready && (a < M * N);
    wr_bank = PW'(row % P);
    wr_idx  = BAW'((row / P) * N + col);
  end

  // Weight banks: gated write, synchronous one-cycle read per lane.
  // NOTE: memory arrays carry no reset so they map onto RAM; weights persist across reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      if (wr_hit && int'(wr_bank) == p) w_mem[p][wr_idx] <= w_data;
      w_q[p] <= w_mem[p][rd_addr];
    end
  end

  // x buffer capture and read, with bypass when the element being read arrives on this edge.
  always_ff @(posedge clk) begin
    if (accept) x_buf[x_cnt] <= input_data;
    x_q <= (accept && x_cnt == rd_col) ? input_data : x_buf[rd_col];
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    fc_mac_lane #(.T(T), .N(N), .R(R)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (lane_clr),
      .en     (lane_en),
      .w      (w_q[p]),
      .x      (x_q),
      .result (lane_res[p])
    );
  end

  // Control FSM with registered handshake outputs and the output register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD_X;
      x_cnt        <= '0;
      col_cnt      <= '0;
      grp          <= '0;
      drain_idx    <= '0;
      input_ready  <= 1'b0;
      w_ready      <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= '0;
      for (int p = 0; p < P; p++) out_rf[p] <= '0;
    end else begin
      unique case (state)
        LOAD_X: begin
          if (accept) begin
            w_ready <= 1'b0;
            if (x_cnt == XW'(N - 1)) begin
              state       <= COMPUTE;
              x_cnt       <= '0;
              col_cnt     <= '0;
              input_ready <= 1'b0;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end else begin
            input_ready <= 1'b1;
            w_ready     <= (x_cnt == '0);
          end
        end
        COMPUTE: begin
          if (col_cnt == CW'(N)) begin
            state        <= DRAIN;
            drain_idx    <= '0;
            output_valid <= 1'b1;
            output_data  <= lane_res[0];
            for (int p = 0; p < P; p++) out_rf[p] <= lane_res[p];
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (drain_idx == PW'(P - 1)) begin
              output_valid <= 1'b0;
              drain_idx    <= '0;
              col_cnt      <= '0;
              if (grp == GW'(G - 1)) begin
                state       <= LOAD_X;
                grp         <= '0;
                input_ready <= 1'b1;
                w_ready     <= 1'b1;
              end else begin
                state <= COMPUTE;
                grp   <= grp + 1'b1;
              end
            end else begin
              drain_idx   <= drain_idx + 1'b1;
              output_data <= out_rf[drain_idx + 1'b1];
            end
          end
        end
        default: state <= LOAD_X;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mvm_par.sv
// Directed bench for fc_mvm_par: ReLU and linear instances driven in lockstep.
module tb_fc_mvm_par;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int AW = $clog2(M * N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          input_valid = 1'b0;
  logic [T-1:0]  input_data = '0;
  logic          output_ready = 1'b0;
  logic          w_wr_en = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [T-1:0]  w_data = '0;

  logic          input_ready, output_valid, w_ready;
  logic [T-1:0]  output_data;
  logic          lin_input_ready, lin_output_valid, lin_w_ready;
  logic [T-1:0]  lin_output_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xv [N];
  int wv [M*N];
  int exp_r1 [M];
  int exp_r0 [M];
  int t_first_acc = 0;
  int t_last_acc  = 0;

  fc_mvm_par #(.M(M), .N(N), .T(T), .P(P), .R(1)) u_dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready)
  );

  fc_mvm_par #(.M(M), .N(N), .T(T), .P(P), .R(0)) u_dut_lin (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(lin_input_ready), .input_data(input_data),
    .output_valid(lin_output_valid), .output_ready(output_ready), .output_data(lin_output_data),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(lin_w_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sv(input logic [T-1:0] v);
    return int'($signed(v));
  endfunction

  // Writes the whole wv table; called at a negedge with w_ready high.
  task automatic write_weights();
    check("w_ready_before_write", w_ready, 1);
    for (int i = 0; i < M * N; i++) begin
      w_wr_en = 1'b1;
      w_addr  = AW'(i);
      w_data  = T'(wv[i]);
      @(negedge clk);
    end
    w_wr_en = 1'b0;
  endtask

  // Streams xv[lo..hi]; returns at the negedge after the last accept.
  task automatic send_elems(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int budget;
      budget      = 0;
      input_valid = 1'b1;
      input_data  = T'(xv[i]);
      while (!input_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!input_ready) check($sformatf("send_timeout_x%0d", i), 0, 1);
      if (i == 0) t_first_acc = cyc;
      if (i == N - 1) t_last_acc = cyc;
      @(negedge clk);
    end
    input_valid = 1'b0;
  endtask

  // Collects cnt outputs against exp_r1/exp_r0; optional ready toggling and timing checks.
  task automatic collect(input string tag, input int cnt, input bit toggle, input bit timing);
    int           got_n;
    int           budget;
    int           prev_t;
    bit           stalled;
    logic [T-1:0] held;
    got_n   = 0;
    budget  = 0;
    prev_t  = 0;
    stalled = 1'b0;
    held    = '0;
    while (got_n < cnt && budget < 200) begin
      output_ready = toggle ? ~output_ready : 1'b1;
      if (stalled) begin
        check($sformatf("%s_hold_valid", tag), output_valid, 1);
        check($sformatf("%s_hold_data", tag), sv(output_data), sv(held));
        stalled = 1'b0;
      end
      if (output_valid) begin
        input_valid = 1'b0;
        if (output_ready) begin
          check($sformatf("%s_y%0d", tag, got_n), sv(output_data), exp_r1[got_n]);
          check($sformatf("%s_lin_valid%0d", tag, got_n), lin_output_valid, 1);
          check($sformatf("%s_lin_y%0d", tag, got_n), sv(lin_output_data), exp_r0[got_n]);
          if (timing) begin
            if (got_n == 0) check($sformatf("%s_first_latency", tag), cyc - t_last_acc, N + 2);
            if (got_n == P) check($sformatf("%s_group_gap", tag), cyc - prev_t, N + 2);
            if (got_n == M - 1)
              check($sformatf("%s_vector_span", tag), cyc - t_first_acc + 1, N + (M / P) * (N + 1 + P));
          end
          prev_t = cyc;
          got_n++;
        end else begin
          stalled = 1'b1;
          held    = output_data;
        end
      end
      @(negedge clk);
      budget++;
    end
    if (got_n < cnt) check($sformatf("%s_timeout", tag), got_n, cnt);
    output_ready = 1'b0;
  endtask

  initial begin
    // Reset values and release.
    repeat (2) @(negedge clk);
    check("rst_input_ready", input_ready, 0);
    check("rst_output_valid", output_valid, 0);
    check("rst_output_data", sv(output_data), 0);
    check("rst_w_ready", w_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_input_ready", input_ready, 1);
    check("post_rst_w_ready", w_ready, 1);

    // Base case, no backpressure, stray input_valid while busy.
    wv = '{1, 2, 3, -1, 0, 1, 4, -4, 0, 0, 0, 127};
    write_weights();
    xv     = '{10, 20, 30};
    exp_r1 = '{127, 20, 0, 127};
    exp_r0 = '{127, 20, -40, 127};
    send_elems(0, N - 1);
    check("busy_input_ready", input_ready, 0);
    check("busy_w_ready", w_ready, 0);
    input_valid = 1'b1;
    input_data  = 8'd99;
    collect("base", M, 1'b0, 1'b1);
    check("reload_input_ready", input_ready, 1);
    check("reload_w_ready", w_ready, 1);
    check("reload_output_valid", output_valid, 0);

    // Backpressure: output_ready toggles every cycle.
    send_elems(0, N - 1);
    collect("stall", M, 1'b1, 1'b0);

    // Reset during COMPUTE of group 1.
    send_elems(0, N - 1);
    collect("pre_rst", P, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_output_valid", output_valid, 0);
    check("midrst_output_data", sv(output_data), 0);
    check("midrst_lin_output_data", sv(lin_output_data), 0);
    check("midrst_input_ready", input_ready, 0);
    check("midrst_w_ready", lin_w_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", lin_input_ready, 1);
    xv     = '{1, 1, 1};
    exp_r1 = '{6, 0, 0, 127};
    exp_r0 = '{6, 0, 0, 127};
    send_elems(0, N - 1);
    collect("post_rst", M, 1'b0, 1'b1);

    // Weight write while busy is dropped; a later legal write lands.
    xv     = '{10, 20, 30};
    exp_r1 = '{127, 20, 0, 127};
    exp_r0 = '{127, 20, -40, 127};
    send_elems(0, 0);
    check("partial_w_ready", w_ready, 0);
    w_wr_en = 1'b1;
    w_addr  = '0;
    w_data  = 8'd5;
    @(negedge clk);
    w_wr_en = 1'b0;
    send_elems(1, N - 1);
    collect("wr_ignored", M, 1'b0, 1'b0);
    check("idle_w_ready", w_ready, 1);
    w_wr_en = 1'b1;
    w_addr  = '0;
    w_data  = T'(-9);
    @(negedge clk);
    w_wr_en = 1'b0;
    exp_r1[0] = 40;
    exp_r0[0] = 40;
    send_elems(0, N - 1);
    collect("wr_row0", M, 1'b0, 1'b0);

    // Extremes: large positive sum saturates, large negative sum clamps or rectifies.
    for (int i = 0; i < M * N; i++) wv[i] = -128;
    write_weights();
    xv     = '{-128, -128, -128};
    exp_r1 = '{127, 127, 127, 127};
    exp_r0 = '{127, 127, 127, 127};
    send_elems(0, N - 1);
    collect("ext_pos", M, 1'b0, 1'b0);
    for (int i = 0; i < M * N; i++) wv[i] = 127;
    write_weights();
    exp_r1 = '{0, 0, 0, 0};
    exp_r0 = '{-128, -128, -128, -128};
    send_elems(0, N - 1);
    collect("ext_neg", M, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_mvm_par.md
# fc_mvm_par

Parametrised fully-connected layer engine: computes y = f(W·x) for an M×N signed weight matrix and an N-element input vector, streaming x in and y out over valid/ready handshakes. Successor to the fixed-size, single-MAC, ROM-weight FC blocks. It adds:
- P parallel MAC lanes;
- a runtime-writable weight memory;
- saturating output;
- selectable ReLU.

It sits between layer buffers in the generated network pipeline.

## Interface
- M, 8: output rows; M % P == 0 required.
- N, 8: input vector length.
- T, 16: signed data/weight width.
- P, 2: parallel MAC lanes (rows computed per group).
- R, 1: 1 = apply ReLU after saturation, 0 = linear.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- input_valid  in  1  input_data valid.
- input_ready  out  1  block accepts an x element.
- input_data  in  T  signed x element, index order 0..N-1.
- output_valid  out  1  output_data valid.
- output_ready  in  1  downstream accepts y.
- output_data  out  T  signed y element, row order 0..M-1.
- w_wr_en  in  1  weight write strobe.
- w_addr  in  clog2(M*N)  weight index, row-major (row*N + col).
- w_data  in  T  signed weight.
- w_ready  out  1  weight writes are accepted this cycle.

## Operation
- FSM states:
  - LOAD_X: accept N elements into the x buffer; transfer on input_valid & input_ready.
  - COMPUTE: run group g (rows g*P .. g*P+P-1).
  - DRAIN: emit the P results of group g.
  - Then either COMPUTE(g+1), or LOAD_X after the last group.
- input_ready = 1 only in LOAD_X.
- w_ready = 1 only in LOAD_X with zero elements accepted so far in the current vector.
  - A w_wr_en while w_ready = 0 is ignored (no write).
  - Write with w_ready = 1 takes effect on that edge.
- Weight memory: P banks, bank p holds rows r where r % P == p. Synchronous read, 1-cycle latency. Contents are not reset.
- COMPUTE:
  - Per column k = 0..N-1: all lanes read x[k] and their bank's weight.
  - Multiply T×T → 2T signed; accumulate in 2T + clog2(N) bits. No overflow is possible internally.
  - Accumulators clear at COMPUTE entry.
- Result of each lane:
  - Saturate the accumulator to signed T-bit: above 2^(T-1)-1 clamps to max, below -2^(T-1) clamps to min.
  - Then, if R = 1, negative values become 0.
- DRAIN:
  - Results are held in a P-entry output register file and presented lane 0..P-1 in order.
  - Advance on output_valid & output_ready.
  - output_valid and output_data hold stable while output_ready = 0.
- Reset mid-operation: state returns to LOAD_X with counters cleared. The partial vector and the partial results are discarded. Weights persist.

## Timing
- Reset values: input_ready = 0, output_valid = 0, output_data = 0, w_ready = 0.
- input_ready and w_ready rise on the first clk edge after reset deasserts.
- LOAD_X → COMPUTE on the edge accepting element N-1. input_ready is 0 on the following cycle.
- COMPUTE lasts N+1 cycles: N address issues, plus 1 read-latency cycle for the final MAC.
- First output_valid is asserted exactly N+2 cycles after the edge accepting x[N-1].
- Inter-group gap: with output_ready held 1, the last output of group g is followed by the first of group g+1 after N+2 cycles.
- Full vector throughput with no backpressure: N accepts + (M/P)·(N+1+P) cycles.
- Simultaneous last-output transfer and return to LOAD_X: input_ready is 1 on the next cycle. No bubble beyond that.
- input_valid asserted outside LOAD_X has no effect. The data is not consumed.

## Structure
- Shared package fc_pkg:
  - state enum typedef (LOAD_X, COMPUTE, DRAIN);
  - saturate-to-T and ReLU functions;
  - accumulator width constant function (2T + clog2(N)).
- Sub-module fc_mac_lane (parameters T, N, R): multiply, accumulate, clear, enable, and saturate/ReLU result output. Instantiated P times in a generate loop.
- The weight banks and the x buffer are inferred arrays in the top level.

## Test plan
Setup for all scenarios: M=4, N=3, T=8, P=2, R=1. W rows = [1,2,3], [-1,0,1], [4,-4,0], [0,0,127]. x = [10,20,30].
- Write W, stream x, output_ready = 1 → outputs 127 (140 saturated), 20, 0 (-40 ReLU), 127 (3810 saturated). First output_valid arrives N+2 = 5 cycles after x[2] is accepted.
- Same configuration with R=0 → outputs 127, 20, -40, 127.
- Toggle output_ready 1/0 every cycle → same four values in order. Data stays stable while stalled. No drops or duplicates.
- Assert w_wr_en for addr 0 with data 5 after x[0] is accepted → write ignored, row 0 result still 127. After the vector completes, write addr 0 = -9 → the next x gives row 0 = -90+40+90 = 40.
- Assert reset during COMPUTE of group 1 → all outputs are 0 during reset. After release, a fresh x = [1,1,1] yields 6, 0, 0, 127 (weights retained).
- Check extremes: all weights -128, x all -128 → accumulator 49152 → output 127. Weights 127, x -128 → output 0 with R=1, -128 with R=0.
